// File: rtl/axi_ethernet_v3_01_a_sync_pkg.sv
// Shared definitions for the synchroniser-output glitch filter.
// Holds the qualify FSM encoding and the qualify counter width.
package axi_ethernet_v3_01_a_sync_pkg;

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_QUALIFY = 1'b1;

  localparam int unsigned Q_CNT_W = 8;

  typedef enum logic {
    StStable  = ST_STABLE,
    StQualify = ST_QUALIFY
  } sync_state_e;

  // Count value at which the next differing sample accepts the change.
  function automatic logic [Q_CNT_W-1:0] q_cnt_last(input int unsigned filter_cycles);
    return Q_CNT_W'(filter_cycles - 1);
  endfunction

endpackage

// File: rtl/axi_ethernet_v3_01_a_sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear that coincides with an event keeps that event (count becomes 1).
module axi_ethernet_v3_01_a_sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 at_max_o,
  output logic                 ovf_evt_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? CNT_WIDTH'(1) : '0;
    end else if (inc_i && !at_max_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign at_max_o  = &count_q;
  assign ovf_evt_o = inc_i & at_max_o;

endmodule

// File: rtl/axi_ethernet_v3_01_a_sync_filter.sv
// Glitch filter on an already-synchronised level: qualifies changes over FILTER_CYCLES
// samples, emits rise/fall strobes and keeps saturating event counts with a sticky overflow.
module axi_ethernet_v3_01_a_sync_filter
  import axi_ethernet_v3_01_a_sync_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 data_sync_i,
  input  logic                 clear_counts_i,
  output logic                 filtered_o,
  output logic                 rise_pulse_o,
  output logic                 fall_pulse_o,
  output logic [CNT_WIDTH-1:0] rise_count_o,
  output logic [CNT_WIDTH-1:0] fall_count_o,
  output logic                 overflow_o
);

  sync_state_e        state_q, state_d;
  logic [Q_CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic               filtered_q, filtered_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               overflow_q, overflow_d;
  logic               differ;
  logic               rise_at_max, fall_at_max;
  logic               rise_ovf_evt, fall_ovf_evt;

  assign differ = data_sync_i != filtered_q;

  always_comb begin
    state_d    = state_q;
    q_cnt_d    = q_cnt_q;
    filtered_d = filtered_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    unique case (state_q)
      StStable: begin
        if (differ) begin
          if (FILTER_CYCLES == 1) begin
            filtered_d = data_sync_i;
            rise_d     = data_sync_i;
            fall_d     = ~data_sync_i;
          end else begin
            state_d = StQualify;
            q_cnt_d = Q_CNT_W'(1);
          end
        end
      end
      StQualify: begin
        if (!differ) begin
          // Input fell back before qualifying: drop it silently.
          state_d = StStable;
          q_cnt_d = '0;
        end else if (q_cnt_q == q_cnt_last(FILTER_CYCLES)) begin
          filtered_d = data_sync_i;
          rise_d     = data_sync_i;
          fall_d     = ~data_sync_i;
          state_d    = StStable;
          q_cnt_d    = '0;
        end else begin
          q_cnt_d = q_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StStable;
        q_cnt_d = '0;
      end
    endcase
  end

  // Overflow clears on request even if an event hits a full counter on the same edge.
  assign overflow_d = clear_counts_i ? 1'b0 : (overflow_q | rise_ovf_evt | fall_ovf_evt);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= StStable;
      q_cnt_q    <= '0;
      filtered_q <= INIT_LEVEL;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_cnt_q    <= q_cnt_d;
      filtered_q <= filtered_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      overflow_q <= overflow_d;
    end
  end

  // Counters see the registered strobes, so they advance the cycle after each strobe.
  axi_ethernet_v3_01_a_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_rise_cnt (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .inc_i     (rise_q),
    .clr_i     (clear_counts_i),
    .count_o   (rise_count_o),
    .at_max_o  (rise_at_max),
    .ovf_evt_o (rise_ovf_evt)
  );

  axi_ethernet_v3_01_a_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fall_cnt (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .inc_i     (fall_q),
    .clr_i     (clear_counts_i),
    .count_o   (fall_count_o),
    .at_max_o  (fall_at_max),
    .ovf_evt_o (fall_ovf_evt)
  );

  assign filtered_o   = filtered_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
  assign overflow_o   = overflow_q;

  logic unused_at_max;
  assign unused_at_max = rise_at_max ^ fall_at_max;

endmodule

// File: tb/tb_axi_ethernet_v3_01_a_sync_filter.sv
// Bench for the sync filter: four configurations driven with shared directed and random
// stimulus, each compared against a run-length reference model.
module tb_axi_ethernet_v3_01_a_sync_filter;

  localparam int NCFG = 4;

  // Configurations: 0 defaults, 1 two-bit counters, 2 INIT_LEVEL=1, 3 FILTER_CYCLES=1 INIT=1.
  function automatic int unsigned fc_of(input int k);
    return (k == 3) ? 1 : 4;
  endfunction
  function automatic int unsigned cw_of(input int k);
    return (k == 1) ? 2 : 16;
  endfunction
  function automatic logic il_of(input int k);
    return (k >= 2);
  endfunction

  logic clk = 1'b0;
  logic resetn;
  logic data_sync;
  logic clear_counts;

  logic        filt_w [NCFG];
  logic        rise_w [NCFG];
  logic        fall_w [NCFG];
  logic        ovf_w  [NCFG];
  logic [31:0] rc_w   [NCFG];
  logic [31:0] fc_w   [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned FC = (g == 3) ? 1 : 4;
    localparam int unsigned CW = (g == 1) ? 2 : 16;
    localparam logic        IL = (g >= 2) ? 1'b1 : 1'b0;
    logic [CW-1:0] rc, fc;
    axi_ethernet_v3_01_a_sync_filter #(
      .FILTER_CYCLES (FC),
      .CNT_WIDTH     (CW),
      .INIT_LEVEL    (IL)
    ) dut (
      .clk_i          (clk),
      .resetn_i       (resetn),
      .data_sync_i    (data_sync),
      .clear_counts_i (clear_counts),
      .filtered_o     (filt_w[g]),
      .rise_pulse_o   (rise_w[g]),
      .fall_pulse_o   (fall_w[g]),
      .rise_count_o   (rc),
      .fall_count_o   (fc),
      .overflow_o     (ovf_w[g])
    );
    assign rc_w[g] = 32'(rc);
    assign fc_w[g] = 32'(fc);
  end

  // Reference model state
  logic        m_filt [NCFG];
  logic        m_rise [NCFG];
  logic        m_fall [NCFG];
  logic        m_ovf  [NCFG];
  int unsigned m_rc   [NCFG];
  int unsigned m_fc   [NCFG];
  int unsigned m_run  [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      m_filt[k] = il_of(k);
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
      m_ovf[k]  = 1'b0;
      m_rc[k]   = 0;
      m_fc[k]   = 0;
      m_run[k]  = 0;
    end
  endtask

  // One rising edge: counters account the strobes of the cycle just ending, then the level
  // changes once the input has disagreed with it for FILTER_CYCLES consecutive samples.
  task automatic model_edge();
    for (int k = 0; k < NCFG; k++) begin
      int unsigned max_cnt;
      max_cnt = (32'd1 << cw_of(k)) - 1;
      if (clear_counts) begin
        m_rc[k]  = m_rise[k] ? 1 : 0;
        m_fc[k]  = m_fall[k] ? 1 : 0;
        m_ovf[k] = 1'b0;
      end else begin
        if (m_rise[k]) begin
          if (m_rc[k] == max_cnt) m_ovf[k] = 1'b1;
          else m_rc[k]++;
        end
        if (m_fall[k]) begin
          if (m_fc[k] == max_cnt) m_ovf[k] = 1'b1;
          else m_fc[k]++;
        end
      end
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
      if (data_sync != m_filt[k]) begin
        m_run[k]++;
        if (m_run[k] >= fc_of(k)) begin
          m_filt[k] = data_sync;
          m_rise[k] = data_sync;
          m_fall[k] = ~data_sync;
          m_run[k]  = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NCFG; k++) begin
      chk("filtered", k, 32'(filt_w[k]), 32'(m_filt[k]));
      chk("rise_pulse", k, 32'(rise_w[k]), 32'(m_rise[k]));
      chk("fall_pulse", k, 32'(fall_w[k]), 32'(m_fall[k]));
      chk("rise_count", k, rc_w[k], m_rc[k]);
      chk("fall_count", k, fc_w[k], m_fc[k]);
      chk("overflow", k, 32'(ovf_w[k]), 32'(m_ovf[k]));
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic d, input logic c);
    data_sync    = d;
    clear_counts = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn       = 1'b1;
    data_sync    = 1'b0;
    clear_counts = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;

    // T1: quiet input after reset
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    chk("t1_filtered", 0, 32'(filt_w[0]), 32'd0);
    chk("t1_rise_count", 0, rc_w[0], 32'd0);

    // T2: held rise qualifies on the 4th sampling edge
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("t2_not_yet", 0, 32'(filt_w[0]), 32'd0);
    step(1'b1, 1'b0);
    chk("t2_filtered", 0, 32'(filt_w[0]), 32'd1);
    chk("t2_rise_pulse", 0, 32'(rise_w[0]), 32'd1);
    step(1'b1, 1'b0);
    chk("t2_pulse_end", 0, 32'(rise_w[0]), 32'd0);
    chk("t2_rise_count", 0, rc_w[0], 32'd1);

    // T3: glitches of 1..3 cycles rejected, 4-cycle pulse accepted both ways
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < w; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
      chk("t3_glitch_level", w, 32'(filt_w[0]), 32'd0);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    chk("t3_rise", 0, 32'(rise_w[0]), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("t3_fall", 0, 32'(fall_w[0]), 32'd1);

    // T4: two-bit rise counter saturates at 3 and flags overflow on the 4th rise
    step(1'b0, 1'b1);
    chk("t4_cleared", 1, rc_w[1], 32'd0);
    for (int r = 1; r <= 5; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("t4_rise_count", 1, rc_w[1], (r < 3) ? 32'(r) : 32'd3);
      chk("t4_overflow", 1, 32'(ovf_w[1]), (r >= 4) ? 32'd1 : 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b1);
    chk("t4_clr_count", 1, rc_w[1], 32'd0);
    chk("t4_clr_overflow", 1, 32'(ovf_w[1]), 32'd0);

    // T5: clear on the edge that counts a rise keeps that rise
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t5_rise_count", 0, rc_w[0], 32'd1);
    chk("t5_rise_count", 1, rc_w[1], 32'd1);
    chk("t5_overflow", 0, 32'(ovf_w[0]), 32'd0);

    // T6: reset during qualification restores INIT_LEVEL without a strobe
    async_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    async_reset();
    chk("t6_init_level", 2, 32'(filt_w[2]), 32'd1);
    chk("t6_no_strobe", 2, 32'(fall_w[2]), 32'd0);

    // Random segments; FILTER_CYCLES=1 tracks the input one cycle late
    for (int s = 0; s < 70; s++) begin
      logic d;
      int   len;
      d   = 1'($urandom_range(1, 0));
      len = int'($urandom_range(6, 1));
      for (int i = 0; i < len; i++) begin
        step(d, ($urandom_range(15, 0) == 0));
        chk("fc1_delay", 3, 32'(filt_w[3]), 32'(d));
      end
      if (s == 35) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
